// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Multi-cycle instruction fetch unit: one bus read per request, PC alignment
// check, and flush handling that drains any bus transaction already in flight.
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              flush,
    output logic              busy,
    output logic              ibus_valid,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_addr_ok,
    input  logic              ibus_data_ok,
    input  logic [DATA_W-1:0] ibus_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_exc,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_HOLD    = 3'd3,
        S_DRAIN_A = 3'd4,
        S_DRAIN_D = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              exc_q, exc_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    // Once the bus has been asked for an address, the transaction must run to
    // completion even after a flush; the drain states absorb it silently.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    pc_d    = start_pc;
                    instr_d = '0;
                    exc_d   = (start_pc[1:0] != 2'b00);
                    state_d = (start_pc[1:0] != 2'b00) ? S_HOLD : S_ADDR;
                end
            end
            S_ADDR: begin
                if (flush) begin
                    if (!ibus_addr_ok)     state_d = S_DRAIN_A;
                    else if (ibus_data_ok) state_d = S_IDLE;
                    else                   state_d = S_DRAIN_D;
                end else if (ibus_addr_ok) begin
                    if (ibus_data_ok) begin
                        instr_d = ibus_data;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (flush) begin
                    state_d = ibus_data_ok ? S_IDLE : S_DRAIN_D;
                end else if (ibus_data_ok) begin
                    instr_d = ibus_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            S_DRAIN_A: begin
                if (ibus_addr_ok) state_d = ibus_data_ok ? S_IDLE : S_DRAIN_D;
            end
            S_DRAIN_D: begin
                if (ibus_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake: a result transfers on a rising edge where out_valid && out_ready
    // && !flush; out_valid and the payload hold steady until then. The bus
    // request likewise holds ibus_valid/ibus_addr steady until ibus_addr_ok.
    always_comb begin
        busy       = (state_q != S_IDLE);
        ibus_valid = (state_q == S_ADDR) || (state_q == S_DRAIN_A);
        out_valid  = (state_q == S_HOLD);
        ibus_addr  = pc_q;
        out_pc     = pc_q;
        out_instr  = instr_q;
        out_exc    = exc_q;
        dbg_state  = state_q;
    end

    a_no_data_when_idle: assert property (@(posedge clk) disable iff (!resetn)
        !(ibus_data_ok && ((state_q == S_IDLE) || (state_q == S_HOLD))));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed table-driven bench for fetch_unit, plus hand sequences for reset.
module tb_fetch_unit;

    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2,
                           S_HOLD = 3'd3, S_DRAIN_A = 3'd4, S_DRAIN_D = 3'd5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0, flush = 1'b0;
    logic [31:0] start_pc = '0;
    logic        busy, ibus_valid, out_valid, out_exc;
    logic [31:0] ibus_addr, out_pc, out_instr;
    logic        ibus_addr_ok = 1'b0, ibus_data_ok = 1'b0, out_ready = 1'b0;
    logic [31:0] ibus_data = '0;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic [31:0] pc;
        logic        flush;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        rdy;
        logic [2:0]  e_state;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_exc;
    } vec_t;

    vec_t vec_q[$];

    fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .start_pc(start_pc),
        .flush(flush), .busy(busy), .ibus_valid(ibus_valid), .ibus_addr(ibus_addr),
        .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_data(ibus_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_exc(out_exc), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [31:0] pc, input logic f,
                       input logic a, input logic d, input logic [31:0] data,
                       input logic r, input logic [2:0] st, input logic [31:0] addr,
                       input logic [31:0] opc, input logic [31:0] oinstr, input logic oexc);
        vec_t v;
        v.start = s; v.pc = pc; v.flush = f; v.aok = a; v.dok = d; v.data = data;
        v.rdy = r; v.e_state = st; v.e_addr = addr; v.e_pc = opc;
        v.e_instr = oinstr; v.e_exc = oexc;
        vec_q.push_back(v);
    endtask

    // Drive one cycle of inputs, then check outputs just after the edge.
    task automatic step(input vec_t v, input int idx);
        logic e_iv, e_ov;
        start = v.start; start_pc = v.pc; flush = v.flush;
        ibus_addr_ok = v.aok; ibus_data_ok = v.dok; ibus_data = v.data;
        out_ready = v.rdy;
        @(posedge clk);
        #1;
        e_iv = (v.e_state == S_ADDR) || (v.e_state == S_DRAIN_A);
        e_ov = (v.e_state == S_HOLD);
        chk("state", idx, {29'd0, dbg_state}, {29'd0, v.e_state});
        chk("busy", idx, {31'd0, busy}, {31'd0, v.e_state != S_IDLE});
        chk("ibus_valid", idx, {31'd0, ibus_valid}, {31'd0, e_iv});
        chk("out_valid", idx, {31'd0, out_valid}, {31'd0, e_ov});
        if (e_iv) chk("ibus_addr", idx, ibus_addr, v.e_addr);
        if (e_ov) begin
            chk("out_pc", idx, out_pc, v.e_pc);
            chk("out_instr", idx, out_instr, v.e_instr);
            chk("out_exc", idx, {31'd0, out_exc}, {31'd0, v.e_exc});
        end
    endtask

    task automatic check_all_zero(input int idx);
        chk("rst_busy", idx, {31'd0, busy}, 32'd0);
        chk("rst_ibus_valid", idx, {31'd0, ibus_valid}, 32'd0);
        chk("rst_out_valid", idx, {31'd0, out_valid}, 32'd0);
        chk("rst_out_exc", idx, {31'd0, out_exc}, 32'd0);
        chk("rst_ibus_addr", idx, ibus_addr, 32'd0);
        chk("rst_out_pc", idx, out_pc, 32'd0);
        chk("rst_out_instr", idx, out_instr, 32'd0);
    endtask

    initial begin
        // Basic fetch, held result for three cycles.
        add(1, 32'hBFC00000, 0, 0, 0, 0, 0, S_ADDR, 32'hBFC00000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, S_DATA, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, S_DATA, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h24020001, 0, S_HOLD, 0, 32'hBFC00000, 32'h24020001, 0);
        add(0, 0, 0, 0, 0, 0, 0, S_HOLD, 0, 32'hBFC00000, 32'h24020001, 0);
        add(0, 0, 0, 0, 0, 0, 0, S_HOLD, 0, 32'hBFC00000, 32'h24020001, 0);
        add(0, 0, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);
        // Same-cycle addr_ok/data_ok.
        add(1, 32'h00400010, 0, 0, 0, 0, 0, S_ADDR, 32'h00400010, 0, 0, 0);
        add(0, 0, 0, 1, 1, 32'h8C430004, 0, S_HOLD, 0, 32'h00400010, 32'h8C430004, 0);
        add(0, 0, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);
        // Misaligned PC: straight to HOLD with exception, no bus access.
        add(1, 32'hBFC00002, 0, 0, 0, 0, 0, S_HOLD, 0, 32'hBFC00002, 32'h0, 1);
        add(0, 0, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);
        // Flush while waiting for addr_ok; start ignored while draining.
        add(1, 32'hBFC00100, 0, 0, 0, 0, 0, S_ADDR, 32'hBFC00100, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, S_DRAIN_A, 32'hBFC00100, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, S_DRAIN_A, 32'hBFC00100, 0, 0, 0);
        add(1, 32'h11111110, 0, 0, 0, 0, 0, S_DRAIN_A, 32'hBFC00100, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, S_DRAIN_D, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, S_DRAIN_D, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, S_IDLE, 0, 0, 0, 0);
        add(1, 32'h00000040, 0, 0, 0, 0, 0, S_ADDR, 32'h00000040, 0, 0, 0);
        add(0, 0, 0, 1, 1, 32'h00000001, 0, S_HOLD, 0, 32'h00000040, 32'h00000001, 0);
        // Flush in HOLD beats a same-cycle out_ready.
        add(0, 0, 1, 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);
        // start with flush in IDLE is dropped.
        add(1, 32'h00000080, 1, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0);
        // ADDR flush with addr_ok only -> DRAIN_D.
        add(1, 32'h00000100, 0, 0, 0, 0, 0, S_ADDR, 32'h00000100, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, S_DRAIN_D, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00000005, 0, S_IDLE, 0, 0, 0, 0);
        // ADDR flush with addr_ok and data_ok -> IDLE.
        add(1, 32'h00000104, 0, 0, 0, 0, 0, S_ADDR, 32'h00000104, 0, 0, 0);
        add(0, 0, 1, 1, 1, 32'h00000006, 0, S_IDLE, 0, 0, 0, 0);
        // DATA flush without data_ok -> DRAIN_D; second flush has no effect.
        add(1, 32'h00000108, 0, 0, 0, 0, 0, S_ADDR, 32'h00000108, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, S_DATA, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, S_DRAIN_D, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, S_DRAIN_D, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00000007, 0, S_IDLE, 0, 0, 0, 0);
        // DATA flush with data_ok -> IDLE, data discarded.
        add(1, 32'h0000010C, 0, 0, 0, 0, 0, S_ADDR, 32'h0000010C, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, S_DATA, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 32'h00000008, 0, S_IDLE, 0, 0, 0, 0);
        // DRAIN_A with addr_ok and data_ok together -> IDLE.
        add(1, 32'h00000110, 0, 0, 0, 0, 0, S_ADDR, 32'h00000110, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, S_DRAIN_A, 32'h00000110, 0, 0, 0);
        add(0, 0, 0, 1, 1, 32'h00000009, 0, S_IDLE, 0, 0, 0, 0);
        // start ignored in HOLD; result stays stable.
        add(1, 32'h00000200, 0, 0, 0, 0, 0, S_ADDR, 32'h00000200, 0, 0, 0);
        add(0, 0, 0, 1, 1, 32'h00000009, 0, S_HOLD, 0, 32'h00000200, 32'h00000009, 0);
        add(1, 32'h00000300, 0, 0, 0, 0, 0, S_HOLD, 0, 32'h00000200, 32'h00000009, 0);
        add(0, 0, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);
        // Back-to-back start; address request held without addr_ok.
        add(1, 32'h00000400, 0, 0, 0, 0, 0, S_ADDR, 32'h00000400, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, S_ADDR, 32'h00000400, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, S_DATA, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0000000A, 0, S_HOLD, 0, 32'h00000400, 32'h0000000A, 0);
        add(0, 0, 0, 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(-1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vec_q.size(); i++) step(vec_q[i], i);

        // Async reset while in DATA: outputs clear without a clock edge.
        begin
            vec_t v;
            v = vec_q[0];
            v.pc = 32'h00000500; v.e_addr = 32'h00000500;
            step(v, 100);
            v = vec_q[1];
            step(v, 101);
            start = 1'b0; ibus_addr_ok = 1'b0; ibus_data_ok = 1'b0;
            #2;
            resetn = 1'b0;
            #1;
            check_all_zero(102);
            chk("rst_state", 102, {29'd0, dbg_state}, {29'd0, S_IDLE});
            #2;
            resetn = 1'b1;
            @(posedge clk);
            #1;
            v = vec_q[0];
            v.pc = 32'h00000600; v.e_addr = 32'h00000600;
            step(v, 103);
            v = vec_q[8];
            v.data = 32'h0000000C; v.e_pc = 32'h00000600; v.e_instr = 32'h0000000C;
            step(v, 104);
            v = vec_q[9];
            step(v, 105);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch unit for the reference CPU. It issues one instruction-bus read per request, captures the returned word, and presents `{pc, instr, exc}` to the decode stage over a valid/ready handshake. It is the producer side of the instruction word that decode consumes. It owns alignment checking of the fetch PC and cancellation of in-flight bus transactions on `flush`.

## Interface
- `ADDR_W`, 32: PC / bus address width.
- `DATA_W`, 32: instruction word width.
- `clk`  in  1  system clock, all state updates on rising edge.
- `resetn`  in  1  reset is asynchronous and active-low.
- `start`  in  1  fetch request, sampled only when `busy`=0.
- `start_pc`  in  ADDR_W  PC to fetch, sampled with `start`.
- `flush`  in  1  cancel current fetch, any state.
- `busy`  out  1  1 in every state except IDLE.
- `ibus_valid`  out  1  bus address request.
- `ibus_addr`  out  ADDR_W  bus address, = latched PC.
- `ibus_addr_ok`  in  1  address accepted.
- `ibus_data_ok`  in  1  read data returned.
- `ibus_data`  in  DATA_W  read data, valid with `ibus_data_ok`.
- `out_valid`  out  1  fetched result available.
- `out_ready`  in  1  decode accepts result.
- `out_pc`  out  ADDR_W  PC of result.
- `out_instr`  out  DATA_W  instruction word, 0 on exception.
- `out_exc`  out  1  1 = address-error-on-fetch (AdEL).

## Operation
- States: IDLE, ADDR, DATA, HOLD, DRAIN_A, DRAIN_D.
- IDLE: `start`=1 and `flush`=0 latches `start_pc`.
  - `start_pc[1:0]`≠0: go to HOLD with `out_exc`=1, `out_instr`=0. No bus access is made.
  - Otherwise go to ADDR.
  - `start` and `flush` together in IDLE: `flush` wins and the request is dropped.
- ADDR: `ibus_valid`=1, `ibus_addr`=latched PC. It stays asserted and stable until `ibus_addr_ok`.
  - `addr_ok` & `data_ok` in the same cycle: capture `ibus_data`, go to HOLD.
  - `addr_ok` alone: go to DATA.
- DATA: `ibus_valid`=0. On `data_ok`, capture data and go to HOLD.
- HOLD: `out_valid`=1. `out_pc`, `out_instr` and `out_exc` are stable until `out_ready`=1, then go to IDLE.
- Flush:
  - ADDR, no `addr_ok` this cycle: go to DRAIN_A. `ibus_valid` stays 1 (the bus request is never withdrawn).
  - ADDR with `addr_ok` and no `data_ok`: go to DRAIN_D.
  - ADDR with `addr_ok` and `data_ok`: go to IDLE.
  - DATA, no `data_ok`: go to DRAIN_D.
  - DATA with `data_ok`: go to IDLE, data discarded.
  - HOLD: go to IDLE and `out_valid` drops next cycle, even if `out_ready`=1 in the same cycle. Decode must treat a same-cycle flush as no transfer.
  - DRAIN_A or DRAIN_D: no effect.
- DRAIN_A: `ibus_valid`=1 until `addr_ok`.
  - `addr_ok` with `data_ok`: go to IDLE.
  - `addr_ok` alone: go to DRAIN_D.
- DRAIN_D: wait for `data_ok`, discard the data, go to IDLE. `out_valid` is never asserted for a drained fetch.
- At most one outstanding bus transaction at any time. `start` is ignored while `busy`=1.
- `data_ok` in IDLE or HOLD is a protocol violation. It is ignored and flagged by a simulation assertion.

## Timing
- Reset (async, `resetn`=0): state=IDLE. `busy`, `ibus_valid`, `out_valid` and `out_exc` are 0. `ibus_addr`, `out_pc` and `out_instr` are 0.
- Reset asserted mid-transaction returns to IDLE immediately and the outstanding response is forgotten. The bus slave is reset by the same `resetn`.
- All outputs are decoded from registered state and datapath registers. There is no combinational path from any input to any output.
- `start` in cycle 0 gives `ibus_valid`=1 in cycle 1.
- Minimum latency, `start` to `out_valid`: 2 cycles (`addr_ok`+`data_ok` both in cycle 1, `out_valid` in cycle 2).
- With `addr_ok` in cycle 1 and `data_ok` in cycle 2, `out_valid` rises in cycle 3.
- Misaligned PC: `start` in cycle 0 gives `out_valid`=1 with `out_exc`=1 in cycle 1.
- Back-to-back: a handshake in cycle N (`out_valid`&`out_ready`) puts the unit in IDLE in N+1. A new `start` is accepted in N+1. Throughput is at most one fetch per 3 cycles.
- `busy` rises the cycle after an accepted `start` and falls the cycle after the exit to IDLE.

## Test plan
- Basic fetch: `start_pc`=0xBFC00000, `addr_ok` in cycle 1, `data_ok` with data 0x24020001 in cycle 3 → `out_valid` in cycle 4 with `out_pc`=0xBFC00000, `out_instr`=0x24020001, `out_exc`=0. The result is held for 3 cycles while `out_ready`=0.
- Same-cycle handshake: `addr_ok`, `data_ok` and data 0x8C430004 all in cycle 1 → `out_valid` in cycle 2. `ibus_valid` is 1 for exactly one cycle.
- Misaligned PC: `start_pc`=0xBFC00002 → no `ibus_valid` at any time. Next cycle `out_valid`=1, `out_exc`=1, `out_instr`=0, `out_pc`=0xBFC00002.
- Flush while waiting for `addr_ok`: `ibus_valid` stays 1 with a stable address. `addr_ok` in cycle 4, `data_ok` in cycle 6 → `out_valid` is never asserted. `busy` falls in cycle 7. A `start` in cycle 7 is accepted.
- Flush in HOLD with `out_ready`=1 in the same cycle → `out_valid`=0 next cycle, state IDLE.
- Async reset mid-DATA: `resetn` pulses low between clock edges → all outputs are 0 immediately, `busy`=0. A fresh fetch after release completes normally.
